// File: rtl/gpu_l1_miss_fill.sv
// L1 miss/line-fill unit: queues and merges line misses, issues one burst read per
// line, assembles the returned beats into a full line and hands it back to L1.
module gpu_l1_miss_fill #(
  parameter int ADDR_W   = 13,
  parameter int OFFSET_W = 8,
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 32,
  parameter int MQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ready,
  output logic                     mem_req_valid,
  output logic [ADDR_W-OFFSET_W-1:0] mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [BEAT_W-1:0]        mem_rsp_data,
  output logic                     fill_valid,
  output logic [ADDR_W-OFFSET_W-1:0] fill_line_addr,
  output logic [LINE_W-1:0]        fill_data,
  input  logic                     fill_ready,
  output logic                     busy,
  output logic [7:0]               merge_cnt
);

  localparam int LINE_AW = ADDR_W - OFFSET_W;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int BEAT_CW = $clog2(BEATS);
  localparam int PTR_W   = $clog2(MQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source
  // holds valid and its payload stable until that edge. All outputs come from flops.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_FILL} state_t;

  state_t                 state_q, state_d;
  logic [LINE_AW-1:0]     mq_line [MQ_DEPTH];
  logic [MQ_DEPTH-1:0]    mq_vld;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       mq_cnt;
  logic [LINE_AW-1:0]     cur_line;
  logic [BEAT_CW-1:0]     beat_q;
  logic [LINE_W-1:0]      line_buf;
  logic [7:0]             merge_q;

  logic [LINE_AW-1:0]     miss_line;
  logic                   hit, accept, push, pop, merge;
  logic                   unused_offset;

  assign miss_line     = miss_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  // Slot availability comes from the registered count only, so a pop in the same
  // cycle never frees room for that cycle's miss.
  assign miss_ready = (mq_cnt != CNT_W'(MQ_DEPTH));
  assign accept     = miss_valid && miss_ready;
  assign pop        = (state_q == S_IDLE) && (mq_cnt != '0);

  always_comb begin
    hit = (state_q != S_IDLE) && (cur_line == miss_line);
    for (int i = 0; i < MQ_DEPTH; i++) begin
      if (mq_vld[i] && (mq_line[i] == miss_line)) hit = 1'b1;
    end
  end

  assign push  = accept && !hit;
  assign merge = accept && hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop) state_d = S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_RECV;
      S_RECV: if (mem_rsp_valid && (beat_q == BEAT_CW'(BEATS - 1))) state_d = S_FILL;
      S_FILL: if (fill_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MQ_DEPTH; i++) mq_line[i] <= '0;
      mq_vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mq_cnt <= '0;
    end else begin
      if (push) begin
        mq_line[wr_ptr] <= miss_line;
        mq_vld[wr_ptr]  <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        mq_vld[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   mq_cnt <= mq_cnt + CNT_W'(1);
        2'b01:   mq_cnt <= mq_cnt - CNT_W'(1);
        default: mq_cnt <= mq_cnt;
      endcase
    end
  end

  // Beats are only captured in RECV; strays in any other state are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_line <= '0;
      beat_q   <= '0;
      line_buf <= '0;
    end else begin
      if (pop) cur_line <= mq_line[rd_ptr];
      if ((state_q == S_REQ) && mem_req_ready) beat_q <= '0;
      if ((state_q == S_RECV) && mem_rsp_valid) begin
        line_buf[beat_q*BEAT_W +: BEAT_W] <= mem_rsp_data;
        beat_q <= (beat_q == BEAT_CW'(BEATS - 1)) ? '0 : beat_q + BEAT_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       merge_q <= '0;
    else if (merge && merge_q != 8'hFF) merge_q <= merge_q + 8'd1;
  end

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = cur_line;
  assign fill_valid     = (state_q == S_FILL);
  assign fill_line_addr = cur_line;
  assign fill_data      = line_buf;
  assign busy           = (mq_cnt != '0) || (state_q != S_IDLE);
  assign merge_cnt      = merge_q;

endmodule
